// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - instruction, writeback and EX/MEM bundle for ex_stage
interface ex_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [3:0]  alu_op;
  logic [4:0]  addr_1;
  logic [4:0]  addr_2;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic [31:0] imm;
  logic        use_imm;
  logic [4:0]  dest_addr;
  logic        reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        write;
  logic        out_valid;
  logic [4:0]  out_dest;
  logic [31:0] out_data;
  logic        out_write;

  modport master (
    output in_valid, flush, alu_op, addr_1, addr_2, data_1, data_2, imm, use_imm,
           dest_addr, reg_write, wb_addr, wb_data, write,
    input  in_ready, out_valid, out_dest, out_data, out_write
  );

  modport slave (
    input  in_valid, flush, alu_op, addr_1, addr_2, data_1, data_2, imm, use_imm,
           dest_addr, reg_write, wb_addr, wb_data, write,
    output in_ready, out_valid, out_dest, out_data, out_write
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding ALU plus 32-edge iterative MULTU/DIVU with HI/LO
module ex_stage (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_LUI = 4'd15;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e      state, next_state;
  logic [4:0]  counter;
  logic [31:0] hi, lo;
  logic [31:0] acc_hi, acc_lo, op_reg;
  logic [31:0] op_a, op_b, alu_result;
  logic        accept, is_mdu;
  logic [32:0] mul_sum, div_sh;
  logic [31:0] div_diff;
  logic        div_ok;
  logic [31:0] iter_hi, iter_lo;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign is_mdu       = (bus.alu_op == OP_MULTU) || (bus.alu_op == OP_DIVU);

  // Forwarding priority: register 0, then EX/MEM register, then writeback bus.
  always_comb begin
    op_a = bus.data_1;
    if (bus.addr_1 == 5'd0)
      op_a = 32'd0;
    else if (bus.out_valid && bus.out_write && bus.out_dest == bus.addr_1)
      op_a = bus.out_data;
    else if (bus.write && bus.wb_addr == bus.addr_1)
      op_a = bus.wb_data;

    op_b = bus.data_2;
    if (bus.addr_2 == 5'd0)
      op_b = 32'd0;
    else if (bus.out_valid && bus.out_write && bus.out_dest == bus.addr_2)
      op_b = bus.out_data;
    else if (bus.write && bus.wb_addr == bus.addr_2)
      op_b = bus.wb_data;
    if (bus.use_imm)
      op_b = bus.imm;
  end

  always_comb begin
    alu_result = 32'd0;
    case (bus.alu_op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_result = {31'd0, op_a < op_b};
      OP_SLL:  alu_result = op_b << op_a[4:0];
      OP_SRL:  alu_result = op_b >> op_a[4:0];
      OP_SRA:  alu_result = $signed(op_b) >>> op_a[4:0];
      OP_MFHI: alu_result = hi;
      OP_MFLO: alu_result = lo;
      OP_LUI:  alu_result = {op_b[15:0], 16'd0};
      default: alu_result = 32'd0;
    endcase
  end

  // acc_hi:acc_lo is the partial product (MUL) or remainder:quotient-dividend (DIV).
  // A zero divisor falls out naturally: every trial subtract succeeds, giving all-ones
  // quotient and the dividend shifted fully into the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_reg} : 33'd0);
    div_sh   = {acc_hi, acc_lo[31]};
    div_ok   = div_sh >= {1'b0, op_reg};
    div_diff = div_sh[31:0] - op_reg;
    if (state == MUL) begin
      iter_hi = mul_sum[32:1];
      iter_lo = {mul_sum[0], acc_lo[31:1]};
    end else begin
      iter_hi = div_ok ? div_diff : div_sh[31:0];
      iter_lo = {acc_lo[30:0], div_ok};
    end
  end

  always_comb begin
    next_state = state;
    if (bus.flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && bus.alu_op == OP_MULTU) next_state = MUL;
          else if (accept && bus.alu_op == OP_DIVU) next_state = DIV;
        end
        MUL, DIV: if (counter == 5'd31) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter       <= 5'd0;
      hi            <= 32'd0;
      lo            <= 32'd0;
      acc_hi        <= 32'd0;
      acc_lo        <= 32'd0;
      op_reg        <= 32'd0;
      bus.out_valid <= 1'b0;
      bus.out_write <= 1'b0;
      bus.out_dest  <= 5'd0;
      bus.out_data  <= 32'd0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.flush) begin
        bus.out_write <= 1'b0;
        counter       <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && is_mdu) begin
              acc_hi  <= 32'd0;
              acc_lo  <= op_a;
              op_reg  <= op_b;
              counter <= 5'd0;
            end else if (accept) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= alu_result;
              bus.out_dest  <= bus.dest_addr;
              bus.out_write <= bus.reg_write && (bus.dest_addr != 5'd0);
            end
          end
          MUL, DIV: begin
            acc_hi  <= iter_hi;
            acc_lo  <= iter_lo;
            counter <= counter + 5'd1;
            if (counter == 5'd31) begin
              hi            <= iter_hi;
              lo            <= iter_lo;
              bus.out_valid <= 1'b1;
              bus.out_write <= 1'b0;
              bus.out_dest  <= 5'd0;
              bus.out_data  <= iter_lo;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - vector table, directed multi-cycle cases and random model check for ex_stage
module tb_ex_stage;
  localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, NOR_ = 5, SLT = 6, SLTU = 7;
  localparam logic [3:0] SLL = 8, SRL = 9, SRA = 10, MULTU = 11, DIVU = 12, MFHI = 13, MFLO = 14, LUI = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  ex_stage_if bus();
  ex_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  a2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        ui;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  logic [31:0] m_hi, m_lo, m_data;
  logic        m_valid, m_write;
  logic [4:0]  m_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.in_valid = 0; bus.flush = 0; bus.alu_op = 0; bus.addr_1 = 0; bus.addr_2 = 0;
    bus.data_1 = 0; bus.data_2 = 0; bus.imm = 0; bus.use_imm = 0; bus.dest_addr = 0;
    bus.reg_write = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.write = 0;
  endtask

  task automatic set_ins(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic ui, input logic [4:0] dest, input logic rw);
    bus.alu_op = op; bus.addr_1 = a1; bus.data_1 = d1; bus.addr_2 = a2; bus.data_2 = d2;
    bus.imm = imm; bus.use_imm = ui; bus.dest_addr = dest; bus.reg_write = rw; bus.in_valid = 1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic ui, input logic [4:0] dest, input logic rw);
    set_ins(op, a1, d1, a2, d2, imm, ui, dest, rw);
    step;
    bus.in_valid = 0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      step;
      cyc++;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(MFHI, 0, 0, 0, 0, 0, 0, 0, 0);
    chk({tag, " HI"}, bus.out_data, exp_hi);
    issue(MFLO, 0, 0, 0, 0, 0, 0, 0, 0);
    chk({tag, " LO"}, bus.out_data, exp_lo);
  endtask

  task automatic mdu(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    issue(op, 1, a, 2, b, 0, 0, 0, 0);
    wait_ready(cyc);
    chk({tag, " latency"}, cyc, 32);
    chk({tag, " done valid"}, {31'd0, bus.out_valid}, 1);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] pick(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return 0;
    if (m_valid && m_write && m_dest == a) return m_data;
    if (bus.write && bus.wb_addr == a) return bus.wb_data;
    return d;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:  return a + b;
      SUB:  return a - b;
      AND_: return a & b;
      OR_:  return a | b;
      XOR_: return a ^ b;
      NOR_: return ~(a | b);
      SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      SLTU: return (a < b) ? 1 : 0;
      SLL:  return b << a[4:0];
      SRL:  return b >> a[4:0];
      SRA:  return $signed(b) >>> a[4:0];
      MFHI: return m_hi;
      MFLO: return m_lo;
      LUI:  return {b[15:0], 16'd0};
      default: return 0;
    endcase
  endfunction

  initial begin
    int cyc, low, seen;
    logic [63:0] prod;
    logic [31:0] a, b, e;
    logic [3:0] op;

    vecs[0]  = '{ADD,  1, 32'h7FFFFFFF, 2, 32'h1,        0, 0, 32'h80000000};
    vecs[1]  = '{SUB,  1, 32'h0,        2, 32'h1,        0, 0, 32'hFFFFFFFF};
    vecs[2]  = '{SLT,  1, 32'hFFFFFFFF, 2, 32'h1,        0, 0, 32'h1};
    vecs[3]  = '{SLTU, 1, 32'hFFFFFFFF, 2, 32'h1,        0, 0, 32'h0};
    vecs[4]  = '{SLL,  1, 32'h24,       2, 32'h1,        0, 0, 32'h10};
    vecs[5]  = '{SRL,  1, 32'h4,        2, 32'h80000000, 0, 0, 32'h08000000};
    vecs[6]  = '{SRA,  1, 32'h4,        2, 32'h80000000, 0, 0, 32'hF8000000};
    vecs[7]  = '{LUI,  1, 32'h0,        2, 32'h12345678, 32'h0000ABCD, 1, 32'hABCD0000};
    vecs[8]  = '{NOR_, 1, 32'h0,        2, 32'h0F0F0F0F, 0, 0, 32'hF0F0F0F0};
    vecs[9]  = '{XOR_, 1, 32'hA5A5A5A5, 2, 32'hFFFF0000, 0, 0, 32'h5A5AA5A5};
    vecs[10] = '{ADD,  0, 32'h123,      2, 32'h5,        0, 0, 32'h5};
    vecs[11] = '{OR_,  1, 32'hF0,       2, 32'h0,        32'h0F, 1, 32'hFF};
    vecs[12] = '{ADD,  1, 32'hFFFFFFFF, 2, 32'h2,        0, 0, 32'h1};

    idle_in;
    #12;
    chk("reset out_valid", {31'd0, bus.out_valid}, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset in_ready", {31'd0, bus.in_ready}, 1);
    reset = 1;
    step;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a1, vecs[i].d1, vecs[i].a2, vecs[i].d2, vecs[i].imm, vecs[i].ui, 5'd9, 0);
      chk($sformatf("vec%0d valid", i), {31'd0, bus.out_valid}, 1);
      chk($sformatf("vec%0d data", i), bus.out_data, vecs[i].exp);
    end
    step;
    chk("idle clears valid", {31'd0, bus.out_valid}, 0);

    // forwarding: EX/MEM over stale register, register 0, writeback bus
    issue(ADD, 1, 5, 2, 6, 0, 0, 3, 1);
    chk("fwd add", bus.out_data, 11);
    issue(SUB, 3, 100, 4, 1, 0, 0, 4, 1);
    chk("fwd sub", bus.out_data, 10);
    issue(ADD, 0, 99, 5, 7, 0, 0, 0, 1);
    chk("r0 ignores fwd", bus.out_data, 7);
    chk("r0 no write", {31'd0, bus.out_write}, 0);
    bus.write = 1; bus.wb_addr = 6; bus.wb_data = 1000;
    issue(ADD, 6, 1, 0, 0, 0, 0, 2, 1);
    chk("wb fwd", bus.out_data, 1000);
    issue(ADD, 2, 3, 6, 4, 0, 0, 2, 0);
    chk("exmem over wb", bus.out_data, 2000);
    bus.write = 0;

    // MULTU with in_valid held high throughout
    issue(MULTU, 1, 32'hFFFFFFFF, 2, 2, 0, 0, 0, 0);
    set_ins(ADD, 1, 1, 2, 1, 0, 0, 5, 1);
    low = 0; seen = 0;
    while (!bus.in_ready && low < 100) begin
      low++;
      step;
      if (!bus.in_ready && bus.out_valid) seen = 1;
    end
    chk("multu busy cycles", low, 32);
    chk("multu ignores in_valid", seen, 0);
    chk("multu done valid", {31'd0, bus.out_valid}, 1);
    chk("multu done write", {31'd0, bus.out_write}, 0);
    chk("multu done dest", {27'd0, bus.out_dest}, 0);
    set_ins(MFHI, 0, 0, 0, 0, 0, 0, 7, 1);
    step;
    bus.in_valid = 0;
    chk("mfhi after multu", bus.out_data, 1);
    issue(MFLO, 0, 0, 0, 0, 0, 0, 7, 1);
    chk("mflo after multu", bus.out_data, 32'hFFFFFFFE);

    mdu("divu 7/0", DIVU, 7, 0, 7, 32'hFFFFFFFF);
    mdu("divu 100/7", DIVU, 100, 7, 2, 14);

    // flush at iteration 10 of DIVU
    issue(DIVU, 1, 50, 2, 3, 0, 0, 0, 0);
    repeat (10) step;
    bus.flush = 1;
    step;
    bus.flush = 0;
    chk("flush idle", {31'd0, bus.in_ready}, 1);
    chk("flush valid", {31'd0, bus.out_valid}, 0);
    chk("flush write", {31'd0, bus.out_write}, 0);
    seen = 0;
    repeat (40) begin
      step;
      if (bus.out_valid) seen = 1;
    end
    chk("flush no pulse", seen, 0);
    read_hilo("after flush", 2, 14);

    // flush on the completing edge is an abort
    issue(DIVU, 1, 9, 2, 2, 0, 0, 0, 0);
    repeat (31) step;
    bus.flush = 1;
    step;
    bus.flush = 0;
    chk("late flush valid", {31'd0, bus.out_valid}, 0);
    read_hilo("late flush", 2, 14);

    // reset mid-MULTU
    issue(MULTU, 1, 3, 2, 5, 0, 0, 0, 0);
    repeat (5) step;
    #2;
    reset = 0;
    #1;
    chk("rst out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst out_dest", {27'd0, bus.out_dest}, 0);
    chk("rst out_write", {31'd0, bus.out_write}, 0);
    chk("rst in_ready", {31'd0, bus.in_ready}, 1);
    #1;
    reset = 1;
    step;
    read_hilo("after reset", 0, 0);
    step;

    // randomized traffic against the model
    m_hi = 0; m_lo = 0; m_valid = 0; m_write = 0; m_dest = 0; m_data = 0;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.in_valid = 0;
        step;
        chk("rnd idle valid", {31'd0, bus.out_valid}, 0);
        m_valid = 0;
      end else begin
        op = 4'($urandom_range(0, 15));
        bus.write = 1'($urandom);
        bus.wb_addr = 5'($urandom_range(0, 3));
        bus.wb_data = $urandom;
        set_ins(op, 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                $urandom, 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
        a = pick(bus.addr_1, bus.data_1);
        b = bus.use_imm ? bus.imm : pick(bus.addr_2, bus.data_2);
        if (op == MULTU || op == DIVU) begin
          step;
          bus.in_valid = 0;
          wait_ready(cyc);
          chk("rnd mdu latency", cyc, 32);
          chk("rnd mdu valid", {31'd0, bus.out_valid}, 1);
          chk("rnd mdu write", {31'd0, bus.out_write}, 0);
          if (op == MULTU) begin
            prod = 64'(a) * 64'(b);
            m_hi = prod[63:32];
            m_lo = prod[31:0];
          end else if (b == 0) begin
            m_hi = a;
            m_lo = 32'hFFFFFFFF;
          end else begin
            m_hi = a % b;
            m_lo = a / b;
          end
          m_valid = 1; m_write = 0; m_dest = 0;
        end else begin
          e = ref_alu(op, a, b);
          m_write = bus.reg_write && bus.dest_addr != 0;
          m_dest = bus.dest_addr;
          step;
          bus.in_valid = 0;
          chk($sformatf("rnd op%0d data", op), bus.out_data, e);
          chk("rnd valid", {31'd0, bus.out_valid}, 1);
          chk("rnd dest", {27'd0, bus.out_dest}, {27'd0, m_dest});
          chk("rnd write", {31'd0, bus.out_write}, {31'd0, m_write});
          m_valid = 1;
          m_data = e;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
